seq_add_mul_sub: RTL and testbench
==================================

# seq_add_mul_sub

Parametrised, handshaked arithmetic unit and successor to the fixed 4-bit combinational add/multiply/subtract block. It accepts two WIDTH-bit operands and a 2-bit operation code, and returns a 2*WIDTH-bit registered result. Add and subtract complete in one cycle. Unsigned and signed multiply use an iterative radix-2 shift-add datapath. It sits between an operand producer and a result consumer, both using valid/ready handshakes, and applies backpressure while busy.

## Interface
- WIDTH, 4, operand width in bits; legal range 2..32.
- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  synchronous, active-low reset, sampled on the rising edge of clk.
- in_valid  in  1  operand and operation inputs are valid.
- in_ready  out  1  unit accepts inputs this cycle; combinational.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- operation  in  2  operation code: 00 add, 01 subtract (a-b), 10 unsigned multiply, 11 signed multiply.
- out_valid  out  1  result and carry are valid.
- out_ready  in  1  consumer takes the result this cycle.
- result  out  2*WIDTH  registered result.
- carry  out  1  add: carry-out; subtract: borrow (a<b unsigned); multiply: 0.
- busy  out  1  multiply iteration in progress.

## Operation
- Accept: an input is accepted on a rising edge when in_valid && in_ready. Operands and operation are captured on that edge.
- in_ready = rst_n && state==IDLE && (!out_valid || out_ready).
- Add: result = zero-extended a+b. carry = bit WIDTH of the sum. Upper WIDTH-1 bits are 0.
- Subtract: result = (a-b) as 2*WIDTH-bit two's complement, with operands treated as unsigned. carry = (a<b).
- Unsigned multiply: result = a*b, exact in 2*WIDTH bits.
- Signed multiply: result = signed product, exact in 2*WIDTH bits.
  - Implemented as a multiply of the operand magnitudes, then a conditional two's-complement negate when sign(a) XOR sign(b).
  - -2^(WIDTH-1) * -2^(WIDTH-1) = +2^(2*WIDTH-2) must be exact.
- FSM:
  - IDLE: add/sub accept writes result/carry and sets out_valid on the same edge; the state stays IDLE. Multiply accept loads the multiplicand, multiplier, a zero partial product and counter=WIDTH, then moves to MUL.
  - MUL: each edge performs one shift-add step and decrements the counter. The step with counter==1 writes the final (sign-corrected) product into result, sets out_valid, clears carry and returns to IDLE.
- Output register: out_valid holds, and result/carry stay stable, while out_ready=0. out_valid clears on an edge where out_ready=1 unless a new add/sub is accepted on the same edge; in that case it stays high with the new result.
- out_valid is always 0 in MUL, because entry required the output to be empty or draining.
- in_valid and operands are ignored while in_ready=0. Operands changing during MUL do not affect the result.

## Timing
- Reset state: out_valid=0, result=0, carry=0, busy=0, state=IDLE, counter=0. in_ready=0 while rst_n=0 and 1 on the first cycle after release.
- Add/sub latency: 1 cycle. The result is visible in the cycle after the accept edge.
- Add/sub throughput: 1 per cycle when out_ready=1.
- Multiply latency: WIDTH cycles from the accept edge to out_valid. busy=1 for exactly WIDTH-1 cycles, then 0 in the cycle where out_valid rises.
- Multiply throughput: one per WIDTH+1 cycles when out_ready=1. in_ready is 0 during MUL and 1 again in the cycle out_valid rises.
- Reset asserted mid-MUL: the multiply aborts on that edge, no result is produced and the reset state is restored.
- Reset while out_valid=1: the pending result is discarded.

## Test plan
- WIDTH=4, add a=9 b=8 -> one cycle later out_valid=1, result=0x11, carry=1. Then add 3+4 back-to-back with out_ready=1 -> result=0x07, carry=0 on the next cycle.
- WIDTH=4, sub a=3 b=5 -> result=0xFE, carry=1. Sub a=5 b=3 -> result=0x02, carry=0.
- WIDTH=4, umul a=15 b=15 -> busy high 3 cycles, in_ready=0 throughout, out_valid on the 4th cycle after accept with result=0xE1, carry=0.
- WIDTH=4, smul a=0x8 b=0x7 -> result=0xC8 (-56). smul a=0x8 b=0x8 -> result=0x40. smul a=0xF b=0x1 -> result=0xFF.
- Backpressure: add result pending with out_ready=0 for 5 cycles -> result stable, in_ready=0. A new in_valid offered with a different operand is not accepted until out_ready=1.
- Reset mid-multiply: WIDTH=8 umul 255*255, rst_n low on the 3rd MUL cycle -> out_valid never rises, all outputs at reset values. A rerun without reset -> result=0xFE01 after 8 cycles.

Source files
------------

// File: rtl/seq_add_mul_sub.sv
// seq_add_mul_sub: handshaked add / subtract / multiply unit.
// Add and sub finish in one cycle; multiplies iterate one bit per cycle.
module seq_add_mul_sub #(
  parameter int WIDTH = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic [1:0]         operation,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] result,
  output logic               carry,
  output logic               busy
);

  localparam int PW = 2 * WIDTH;
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic {
    IDLE,
    MUL
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [PW-1:0]    mcand_q, mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [PW-1:0]    prod_q, prod_d;
  logic             neg_q, neg_d;
  logic [PW-1:0]    res_q, res_d;
  logic             carry_q, carry_d;
  logic             ov_q, ov_d;

  logic             accept;
  logic             is_mul;
  logic             is_sgn;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;
  logic [WIDTH:0]   sum;
  logic [PW-1:0]    diff;
  logic [PW-1:0]    prod_nx;
  logic             last;

  assign in_ready = rst_n && (state_q == IDLE)
                 && (!ov_q || out_ready);
  assign accept   = in_valid && in_ready;
  assign is_mul   = operation[1];
  assign is_sgn   = operation[0];

  // Signed multiply runs on magnitudes; -2^(W-1) maps to 2^(W-1),
  // which still fits as an unsigned WIDTH-bit value.
  assign a_mag = (is_sgn && a[WIDTH-1]) ? -a : a;
  assign b_mag = (is_sgn && b[WIDTH-1]) ? -b : b;

  assign sum     = {1'b0, a} + {1'b0, b};
  assign diff    = PW'(a) - PW'(b);
  assign prod_nx = prod_q + (mplier_q[0] ? mcand_q : '0);
  assign last    = (cnt_q == CW'(1));

  assign result    = res_q;
  assign carry     = carry_q;
  assign out_valid = ov_q;
  assign busy      = (state_q == MUL) && !last;

  // Next-state: operation dispatch, shift-add step, output handshake
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    prod_d   = prod_q;
    neg_d    = neg_q;
    res_d    = res_q;
    carry_d  = carry_q;
    ov_d     = ov_q && !out_ready;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          if (is_mul) begin
            state_d  = MUL;
            cnt_d    = CW'(WIDTH);
            mcand_d  = PW'(a_mag);
            mplier_d = b_mag;
            prod_d   = '0;
            neg_d    = is_sgn && (a[WIDTH-1] ^ b[WIDTH-1]);
          end else begin
            ov_d    = 1'b1;
            res_d   = is_sgn ? diff : PW'(sum);
            carry_d = is_sgn ? (a < b) : sum[WIDTH];
          end
        end
      end
      MUL: begin
        cnt_d    = cnt_q - CW'(1);
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        prod_d   = prod_nx;
        if (last) begin
          state_d = IDLE;
          ov_d    = 1'b1;
          res_d   = neg_q ? -prod_nx : prod_nx;
          carry_d = 1'b0;
        end
      end
    endcase
  end

  // State and datapath registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      prod_q   <= '0;
      neg_q    <= 1'b0;
      res_q    <= '0;
      carry_q  <= 1'b0;
      ov_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      prod_q   <= prod_d;
      neg_q    <= neg_d;
      res_q    <= res_d;
      carry_q  <= carry_d;
      ov_q     <= ov_d;
    end
  end

endmodule

// File: tb/tb_seq_add_mul_sub.sv
// tb_seq_add_mul_sub: directed vectors plus a scoreboard model.
// WIDTH=4 instance is model-checked; WIDTH=8 covers mid-multiply reset.
module tb_seq_add_mul_sub;

  localparam int W = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           rst_n, in_valid, out_ready;
  logic [W-1:0]   a, b;
  logic [1:0]     op;
  logic           in_ready, out_valid, carry, busy;
  logic [2*W-1:0] result;

  logic        rst8_n, iv8, ordy8;
  logic [7:0]  a8, b8;
  logic [1:0]  op8;
  logic        ir8, ov8, c8, busy8;
  logic [15:0] r8;

  int n_chk = 0;
  int n_fail = 0;

  seq_add_mul_sub #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid),
    .in_ready(in_ready), .a(a), .b(b), .operation(op),
    .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .carry(carry), .busy(busy)
  );

  seq_add_mul_sub #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst8_n), .in_valid(iv8),
    .in_ready(ir8), .a(a8), .b(b8), .operation(op8),
    .out_valid(ov8), .out_ready(ordy8),
    .result(r8), .carry(c8), .busy(busy8)
  );

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Expected {carry, result} from plain integer arithmetic
  function automatic logic [2*W:0] model(input logic [1:0] o,
                                         input logic [W-1:0] x,
                                         input logic [W-1:0] y);
    longint ux, uy, sx, sy, r;
    logic c;
    ux = longint'(x);
    uy = longint'(y);
    sx = x[W-1] ? ux - (longint'(1) << W) : ux;
    sy = y[W-1] ? uy - (longint'(1) << W) : uy;
    c  = 1'b0;
    case (o)
      2'd0: begin r = ux + uy; c = r[W]; end
      2'd1: begin r = ux - uy; c = (ux < uy); end
      2'd2: r = ux * uy;
      default: r = sx * sy;
    endcase
    return {c, r[2*W-1:0]};
  endfunction

  // Scoreboard: accepted requests queue their expected result;
  // every valid output must match the oldest outstanding entry.
  logic [2*W:0] q[$];
  logic hold_v = 1'b0;

  always @(negedge clk) begin
    if (!rst_n) begin
      q.delete();
      hold_v = 1'b0;
      chk("ready_in_reset", in_ready, 0);
    end else begin
      if (hold_v) chk("valid_held", out_valid, 1);
      if (out_valid) begin
        if (q.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL spurious_out: got 0x%0h, want none", result);
        end else begin
          chk("sb_result", result, q[0][2*W-1:0]);
          chk("sb_carry", carry, q[0][2*W]);
          if (out_ready) void'(q.pop_front());
        end
      end
      hold_v = out_valid && !out_ready;
      if (in_valid && in_ready) q.push_back(model(op, a, b));
    end
  end

  task automatic do_mul(input string nm, input logic [1:0] o,
                        input logic [W-1:0] x, input logic [W-1:0] y,
                        input logic [2*W-1:0] er);
    int k;
    int nb;
    logic seen;
    in_valid = 1'b1; op = o; a = x; b = y; out_ready = 1'b1;
    @(negedge clk);
    chk({nm, "_accept_rdy"}, in_ready, 1);
    cyc();
    in_valid = 1'b0; a = ~x; b = ~y;
    k = 0; nb = 0; seen = 1'b0;
    while (k < 4 * W && !seen) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
      else begin
        k++;
        if (busy) nb++;
        chk({nm, "_rdy_mul"}, in_ready, 0);
        cyc();
      end
    end
    chk({nm, "_seen"}, seen, 1);
    chk({nm, "_latency"}, k, W);
    chk({nm, "_busy_cycles"}, nb, W - 1);
    chk({nm, "_result"}, result, er);
    chk({nm, "_carry"}, carry, 0);
    chk({nm, "_busy_done"}, busy, 0);
    chk({nm, "_rdy_done"}, in_ready, 1);
    cyc();
  endtask

  initial begin
    int k;
    logic seen;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    a = '0; b = '0; op = 2'd0;
    rst8_n = 1'b0; iv8 = 1'b0; ordy8 = 1'b1;
    a8 = '0; b8 = '0; op8 = 2'd0;
    repeat (3) cyc();
    @(negedge clk);
    chk("rst_valid", out_valid, 0);
    chk("rst_result", result, 0);
    chk("rst_carry", carry, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ready", in_ready, 0);
    cyc();
    rst_n = 1'b1; rst8_n = 1'b1;
    @(negedge clk);
    chk("ready_after_rst", in_ready, 1);
    cyc();

    // add 9+8 then 3+4 back to back
    in_valid = 1'b1; op = 2'd0; a = 4'd9; b = 4'd8;
    cyc();
    a = 4'd3; b = 4'd4;
    @(negedge clk);
    chk("add98_result", result, 8'h11);
    chk("add98_carry", carry, 1);
    cyc();
    in_valid = 1'b0;
    @(negedge clk);
    chk("add34_valid", out_valid, 1);
    chk("add34_result", result, 8'h07);
    chk("add34_carry", carry, 0);
    cyc();
    @(negedge clk);
    chk("add_drained", out_valid, 0);

    // subtract both directions
    in_valid = 1'b1; op = 2'd1; a = 4'd3; b = 4'd5;
    cyc();
    a = 4'd5; b = 4'd3;
    @(negedge clk);
    chk("sub35_result", result, 8'hFE);
    chk("sub35_carry", carry, 1);
    cyc();
    in_valid = 1'b0;
    @(negedge clk);
    chk("sub53_result", result, 8'h02);
    chk("sub53_carry", carry, 0);
    cyc();

    do_mul("umul_ff", 2'd2, 4'hF, 4'hF, 8'hE1);
    do_mul("smul_87", 2'd3, 4'h8, 4'h7, 8'hC8);
    do_mul("smul_88", 2'd3, 4'h8, 4'h8, 8'h40);
    do_mul("smul_f1", 2'd3, 4'hF, 4'h1, 8'hFF);
    do_mul("umul_a3", 2'd2, 4'hA, 4'h3, 8'h1E);

    // backpressure on a pending add result
    out_ready = 1'b0; in_valid = 1'b1; op = 2'd0; a = 4'd2; b = 4'd3;
    cyc();
    a = 4'd6; b = 4'd1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_valid", out_valid, 1);
      chk("bp_result", result, 8'h05);
      chk("bp_ready", in_ready, 0);
      cyc();
    end
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp_release_rdy", in_ready, 1);
    cyc();
    in_valid = 1'b0;
    @(negedge clk);
    chk("bp_next_result", result, 8'h07);
    cyc();
    @(negedge clk);
    chk("bp_drained", out_valid, 0);

    // WIDTH=8: reset on the 3rd multiply cycle aborts it
    iv8 = 1'b1; op8 = 2'd2; a8 = 8'hFF; b8 = 8'hFF;
    cyc();
    iv8 = 1'b0;
    cyc();
    cyc();
    rst8_n = 1'b0;
    @(negedge clk);
    chk("w8_rdy_in_rst", ir8, 0);
    cyc();
    rst8_n = 1'b1;
    @(negedge clk);
    chk("w8_rst_valid", ov8, 0);
    chk("w8_rst_result", r8, 0);
    chk("w8_rst_carry", c8, 0);
    chk("w8_rst_busy", busy8, 0);
    chk("w8_rst_ready", ir8, 1);
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      cyc();
      @(negedge clk);
      if (ov8) seen = 1'b1;
    end
    chk("w8_aborted_no_out", seen, 0);
    cyc();
    iv8 = 1'b1; op8 = 2'd2; a8 = 8'hFF; b8 = 8'hFF;
    cyc();
    iv8 = 1'b0;
    k = 0; seen = 1'b0;
    while (k < 40 && !seen) begin
      @(negedge clk);
      if (ov8) seen = 1'b1;
      else begin
        k++;
        cyc();
      end
    end
    chk("w8_seen", seen, 1);
    chk("w8_latency", k, 8);
    chk("w8_result", r8, 16'hFE01);
    chk("w8_carry", c8, 0);
    cyc();

    repeat (2) cyc();
    chk("sb_empty", q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
